// File: rtl/wbdram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the pipelined DDR3 controller port.
// Ownership changes only after in-flight requests drain, always with a CYC-low gap.
module wbdram_arbiter #(
  parameter int AW      = 24,
  parameter int DW      = 128,
  parameter int LGHOLD  = 8,
  parameter int LGOUTST = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,

  input  logic              i_a_cyc,
  input  logic              i_a_stb,
  input  logic              i_a_we,
  input  logic [AW-1:0]     i_a_addr,
  input  logic [DW-1:0]     i_a_data,
  input  logic [DW/8-1:0]   i_a_sel,
  output logic              o_a_stall,
  output logic              o_a_ack,
  output logic              o_a_err,
  output logic [DW-1:0]     o_a_data,

  input  logic              i_b_cyc,
  input  logic              i_b_stb,
  input  logic              i_b_we,
  input  logic [AW-1:0]     i_b_addr,
  input  logic [DW-1:0]     i_b_data,
  input  logic [DW/8-1:0]   i_b_sel,
  output logic              o_b_stall,
  output logic              o_b_ack,
  output logic              o_b_err,
  output logic [DW-1:0]     o_b_data,

  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [AW-1:0]     o_wb_addr,
  output logic [DW-1:0]     o_wb_data,
  output logic [DW/8-1:0]   o_wb_sel,
  input  logic              i_wb_stall,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  input  logic [DW-1:0]     i_wb_data
);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, ABORT} state_t;

  localparam logic [LGOUTST-1:0] OUT_MAX  = '1;
  localparam logic [LGOUTST-1:0] OUT_ONE  = {{(LGOUTST-1){1'b0}}, 1'b1};
  localparam logic [LGHOLD-1:0]  HOLD_MAX = '1;
  localparam logic [LGHOLD-1:0]  HOLD_ONE = {{(LGHOLD-1){1'b0}}, 1'b1};

  state_t               state_reg, state_next;
  logic                 owner_reg, owner_next;
  logic                 last_reg, last_next;
  logic [LGOUTST-1:0]   outst_reg, outst_next, outst_step;
  logic [LGHOLD-1:0]    hold_reg, hold_next;

  logic                 own_cyc, own_stb, oth_cyc;
  logic                 full, live, stb_out, accept, pick_b;

  // Owner-side request mux; non-owner request lines are ignored.
  assign own_cyc = owner_reg ? i_b_cyc : i_a_cyc;
  assign own_stb = owner_reg ? i_b_stb : i_a_stb;
  assign oth_cyc = owner_reg ? i_a_cyc : i_b_cyc;

  assign full    = (outst_reg == OUT_MAX);
  assign live    = (state_reg == GRANT) || (state_reg == DRAIN);
  assign stb_out = (state_reg == GRANT) && own_cyc && own_stb && !full;
  assign accept  = stb_out && !i_wb_stall;

  // On a tie the master that was not served last wins.
  assign pick_b  = (i_a_cyc && i_b_cyc) ? ~last_reg : i_b_cyc;

  always_comb begin
    outst_step = outst_reg;
    case ({accept, i_wb_ack})
      2'b10:   outst_step = outst_reg + OUT_ONE;
      2'b01:   outst_step = outst_reg - OUT_ONE;
      default: outst_step = outst_reg;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      outst_reg <= '0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      outst_reg <= outst_next;
      hold_reg  <= hold_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    outst_next = outst_reg;
    hold_next  = hold_reg;
    case (state_reg)
      IDLE: begin
        outst_next = '0;
        if (i_a_cyc || i_b_cyc) begin
          state_next = GRANT;
          owner_next = pick_b;
          last_next  = pick_b;
          hold_next  = '0;
        end
      end
      GRANT: begin
        outst_next = outst_step;
        if (oth_cyc && (hold_reg != HOLD_MAX))
          hold_next = hold_reg + HOLD_ONE;
        if (!own_cyc) begin
          state_next = IDLE;
          outst_next = '0;
        end else if (i_wb_err) begin
          state_next = ABORT;
          outst_next = '0;
        end else if (oth_cyc && (hold_reg == HOLD_MAX)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        outst_next = outst_step;
        if (!own_cyc) begin
          state_next = IDLE;
          outst_next = '0;
        end else if (i_wb_err) begin
          state_next = ABORT;
          outst_next = '0;
        end else if (outst_step == '0) begin
          state_next = IDLE;
        end
      end
      ABORT: begin
        outst_next = '0;
        if (!own_cyc)
          state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        outst_next = '0;
      end
    endcase
  end

  always_comb begin
    o_wb_cyc  = live;
    o_wb_stb  = stb_out;
    o_wb_we   = owner_reg ? i_b_we   : i_a_we;
    o_wb_addr = owner_reg ? i_b_addr : i_a_addr;
    o_wb_data = owner_reg ? i_b_data : i_a_data;
    o_wb_sel  = owner_reg ? i_b_sel  : i_a_sel;

    // Only the owner in GRANT can ever see stall low.
    o_a_stall = !((state_reg == GRANT) && !owner_reg && !i_wb_stall && !full);
    o_b_stall = !((state_reg == GRANT) &&  owner_reg && !i_wb_stall && !full);

    o_a_ack   = i_wb_ack && live && !owner_reg;
    o_b_ack   = i_wb_ack && live &&  owner_reg;
    o_a_err   = i_wb_err && live && !owner_reg;
    o_b_err   = i_wb_err && live &&  owner_reg;

    o_a_data  = i_wb_data;
    o_b_data  = i_wb_data;
  end

endmodule

// File: tb/tb_wbdram_arbiter.sv
// Randomized bench for wbdram_arbiter against a cycle-level model of the arbitration rules.
module tb_wbdram_arbiter;

  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int LGHOLD  = 3;
  localparam int LGOUTST = 2;
  localparam int HMAX    = (1 << LGHOLD) - 1;
  localparam int OMAX    = (1 << LGOUTST) - 1;

  logic            clk = 1'b0;
  logic            i_reset;
  logic            a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [AW-1:0]   a_addr, b_addr;
  logic [DW-1:0]   a_data, b_data;
  logic [DW/8-1:0] a_sel, b_sel;
  logic            o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err;
  logic [DW-1:0]   o_a_data, o_b_data;
  logic            o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0]   o_wb_addr;
  logic [DW-1:0]   o_wb_data;
  logic [DW/8-1:0] o_wb_sel;
  logic            wb_stall, wb_ack, wb_err;
  logic [DW-1:0]   wb_rdata;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Model: which master holds the port (-1 = nobody), whether it is
  // being drained or was aborted, requests in flight, contended cycles.
  int m_grant, m_prev, m_inflight, m_contended;
  bit m_quiesce, m_dead;

  always #5 clk = ~clk;

  wbdram_arbiter #(.AW(AW), .DW(DW), .LGHOLD(LGHOLD), .LGOUTST(LGOUTST)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
    .i_a_data(a_data), .i_a_sel(a_sel),
    .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err), .o_a_data(o_a_data),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
    .i_b_data(b_data), .i_b_sel(b_sel),
    .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err), .o_b_data(o_b_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_grant = -1; m_prev = 1; m_inflight = 0; m_contended = 0;
    m_quiesce = 0; m_dead = 0;
  endtask

  initial begin
    int ack_pct, stall_pct, tog_pct, err_pm;
    bit in_grant, in_drain, busy, e_stb, own_c, oth_c, rst;
    int e_vec, e_stall_a, e_stall_b, n, nw, g;

    i_reset = 1'b1;
    {a_cyc, a_stb, a_we, b_cyc, b_stb, b_we} = '0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0; a_sel = '0; b_sel = '0;
    wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cyc",   int'(o_wb_cyc), 0);
    check_eq("rst_stb",   int'(o_wb_stb), 0);
    check_eq("rst_stall", int'({o_a_stall, o_b_stall}), 3);
    check_eq("rst_resp",  int'({o_a_ack, o_b_ack, o_a_err, o_b_err}), 0);

    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin ack_pct = 30; stall_pct = 20; tog_pct = 5;  err_pm = 5;  end
        1: begin ack_pct = 5;  stall_pct = 10; tog_pct = 2;  err_pm = 3;  end
        2: begin ack_pct = 60; stall_pct = 0;  tog_pct = 1;  err_pm = 2;  end
        default: begin ack_pct = 40; stall_pct = 40; tog_pct = 15; err_pm = 20; end
      endcase
      for (int cyc = 0; cyc < 1500; cyc++) begin
        rst = ((ph | cyc) != 0) && ($urandom_range(0, 399) == 0);
        if ((ph | cyc) == 0) begin
          a_cyc = 1'b1; b_cyc = 1'b1;          // simultaneous request right after reset
        end else begin
          if ($urandom_range(0, 99) < tog_pct) a_cyc = ~a_cyc;
          if ($urandom_range(0, 99) < tog_pct) b_cyc = ~b_cyc;
        end
        a_stb = a_cyc && ($urandom_range(0, 3) != 0);
        b_stb = b_cyc && ($urandom_range(0, 3) != 0);
        a_we = 1'($urandom); b_we = 1'($urandom);
        a_addr = AW'($urandom); b_addr = AW'($urandom);
        a_data = $urandom; b_data = $urandom;
        a_sel = 4'($urandom); b_sel = 4'($urandom);
        wb_rdata = $urandom;
        wb_stall = ($urandom_range(0, 99) < stall_pct);
        i_reset = rst;

        g        = (m_grant < 0) ? 0 : m_grant;
        own_c    = (g == 1) ? b_cyc : a_cyc;
        oth_c    = (g == 1) ? a_cyc : b_cyc;
        in_grant = (m_grant >= 0) && !m_quiesce && !m_dead;
        in_drain = (m_grant >= 0) &&  m_quiesce && !m_dead;
        busy     = in_grant || in_drain;
        // A well-behaved slave only acks what it holds; late/stray acks otherwise.
        wb_ack   = busy ? ((m_inflight > 0) && ($urandom_range(0, 99) < ack_pct))
                        : ($urandom_range(0, 99) < 5);
        wb_err   = busy && ($urandom_range(0, 999) < err_pm);
        #1;

        e_stb     = in_grant && own_c && ((g == 1) ? b_stb : a_stb) && (m_inflight != OMAX);
        e_stall_a = !(in_grant && g == 0 && !wb_stall && m_inflight != OMAX);
        e_stall_b = !(in_grant && g == 1 && !wb_stall && m_inflight != OMAX);
        e_vec = {24'd0, busy, e_stb, e_stall_a[0], e_stall_b[0],
                 wb_ack && busy && g == 0, wb_ack && busy && g == 1,
                 wb_err && busy && g == 0, wb_err && busy && g == 1};
        check_eq("ctl", int'({o_wb_cyc, o_wb_stb, o_a_stall, o_b_stall,
                              o_a_ack, o_b_ack, o_a_err, o_b_err}), e_vec);
        check_eq("rdata", int'(o_a_data ^ o_b_data ^ o_a_data), int'(wb_rdata));
        check_eq("rdata_b", int'(o_b_data), int'(wb_rdata));
        if (e_stb) begin
          check_eq("addr",  int'(o_wb_addr), int'((g == 1) ? b_addr : a_addr));
          check_eq("wdata", int'(o_wb_data), int'((g == 1) ? b_data : a_data));
          check_eq("we_sel", int'({o_wb_we, o_wb_sel}),
                   int'((g == 1) ? {b_we, b_sel} : {a_we, a_sel}));
        end

        if (rst) begin
          model_reset();
        end else if (m_grant < 0) begin
          if (a_cyc || b_cyc) begin
            nw = (a_cyc && b_cyc) ? 1 - m_prev : (b_cyc ? 1 : 0);
            m_grant = nw; m_prev = nw; m_inflight = 0; m_contended = 0;
            m_quiesce = 0; m_dead = 0;
          end
        end else if (m_dead) begin
          if (!own_c) m_grant = -1;
        end else begin
          n = m_inflight + ((e_stb && !wb_stall) ? 1 : 0) - (wb_ack ? 1 : 0);
          if (!own_c) begin
            m_grant = -1; m_inflight = 0;
          end else if (wb_err) begin
            m_dead = 1; m_inflight = 0;
          end else if (m_quiesce) begin
            m_inflight = n;
            if (n == 0) m_grant = -1;
          end else begin
            m_inflight = n;
            if (oth_c) begin
              if (m_contended == HMAX) m_quiesce = 1;
              else m_contended++;
            end
          end
        end
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
